// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller covering load-use, data-memory wait and taken-branch hazards.
// Control outputs decode combinationally from FSM state and hazard inputs; perf counters saturate.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 7,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             Branch_Taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             mem_ack_i,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Pipe_Stall,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam logic [WAIT_W-1:0] MaxWaitCnt = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} stateT;

  stateT             stateReg, stateNext;
  logic [WAIT_W-1:0] waitCntReg, waitCntNext;
  logic              timeoutReg, timeoutNext;
  logic              memWait, loadUse, freeze;

  assign memWait = EX_MEM_MemAccess & ~mem_ack_i;
  assign loadUse = ID_EX_MemRead & (ID_EX_RegisterRt != 5'd0) &
                   ((ID_EX_RegisterRt == IF_ID_RegisterRs) | (ID_EX_RegisterRt == IF_ID_RegisterRt));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg   <= RUN;
      waitCntReg <= '0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      timeoutReg <= timeoutNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    timeoutNext = timeoutReg;
    case (stateReg)
      RUN: begin
        if (memWait) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (mem_ack_i) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCntReg >= MaxWaitCnt) begin
          stateNext   = ERROR;
          timeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCntReg + WAIT_W'(1);
        end
      end
      ERROR:   stateNext = ERROR;
      default: stateNext = RUN;
    endcase
  end

  assign freeze = (stateReg == ERROR) | ((stateReg == MEM_WAIT) & ~mem_ack_i) |
                  ((stateReg == RUN) & memWait);

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Stall   = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        Pipe_Stall  = 1'b1;
      end else if (loadUse) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (Branch_Taken) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

  assign mem_timeout_o = timeoutReg;

  // Index 0 counts stalled-PC cycles, index 1 counts flush pulses.
  logic [1:0] cntInc;
  assign cntInc = {IF_ID_Flush, ~PC_Write} & {2{~rst_i}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gPerf
      logic [CNT_W-1:0] cntReg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cntReg <= '0;
        end else if (cntInc[gi] && (cntReg != {CNT_W{1'b1}})) begin
          cntReg <= cntReg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cycles_o = gPerf[0].cntReg;
  assign flush_count_o  = gPerf[1].cntReg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the stall/flush rules.
module tb_hazard_stall_ctrl;
  localparam int MW  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ID_EX_MemRead;
  logic [4:0]    ID_EX_RegisterRt;
  logic [4:0]    IF_ID_RegisterRs;
  logic [4:0]    IF_ID_RegisterRt;
  logic          Branch_Taken;
  logic          EX_MEM_MemAccess;
  logic          mem_ack_i;
  logic          PC_Write;
  logic          IF_ID_Write;
  logic          IF_ID_Flush;
  logic          ID_EX_Bubble;
  logic          Pipe_Stall;
  logic          mem_timeout_o;
  logic [CW-1:0] stall_cycles_o;
  logic [CW-1:0] flush_count_o;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(.MAX_WAIT(MW), .WAIT_W(7), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .Branch_Taken(Branch_Taken), .EX_MEM_MemAccess(EX_MEM_MemAccess), .mem_ack_i(mem_ack_i),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .Pipe_Stall(Pipe_Stall), .mem_timeout_o(mem_timeout_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle of inputs just after the rising edge; return at the falling edge for sampling.
  task automatic drive(input logic r, input logic mr, input logic [4:0] exRt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic acc, input logic ack);
    @(posedge clk_i);
    #1;
    rst_i = r; ID_EX_MemRead = mr; ID_EX_RegisterRt = exRt;
    IF_ID_RegisterRs = rs; IF_ID_RegisterRt = rt;
    Branch_Taken = br; EX_MEM_MemAccess = acc; mem_ack_i = ack;
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Stall} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 11000", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Stall});
    end
    idle();
    checks++;
    if ({mem_timeout_o, stall_cycles_o, flush_count_o} !== {1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_regs: got to=%b stall=%0d flush=%0d expected 0/0/0", mem_timeout_o, stall_cycles_o, flush_count_o);
    end
    checks++;
    if ({PC_Write, Pipe_Stall} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle: got pc=%b stall=%b expected pc=1 stall=0", PC_Write, Pipe_Stall);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, Pipe_Stall} !== 4'b0010) begin
      errors++;
      $display("FAIL loaduse_ctrl: got %b expected 0010", {PC_Write, IF_ID_Write, ID_EX_Bubble, Pipe_Stall});
    end
    idle();
    checks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL loaduse_release: got %b expected 110", {PC_Write, IF_ID_Write, ID_EX_Bubble});
    end
    checks++;
    if (stall_cycles_o !== 4'd1) begin
      errors++;
      $display("FAIL loaduse_count: got %0d expected 1", stall_cycles_o);
    end
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b10) begin
      errors++;
      $display("FAIL rt_zero_ctrl: got %b expected 10", {PC_Write, ID_EX_Bubble});
    end
    idle();
    checks++;
    if ({stall_cycles_o, flush_count_o} !== {4'd1, 4'd0}) begin
      errors++;
      $display("FAIL rt_zero_count: got stall=%0d flush=%0d expected 1/0", stall_cycles_o, flush_count_o);
    end
    $display("test_load_use done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({PC_Write, IF_ID_Write, Pipe_Stall, ID_EX_Bubble} !== 4'b0010) begin
        errors++;
        $display("FAIL memwait_freeze[%0d]: got %b expected 0010", i, {PC_Write, IF_ID_Write, Pipe_Stall, ID_EX_Bubble});
      end
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({PC_Write, Pipe_Stall} !== 2'b10) begin
      errors++;
      $display("FAIL memwait_ack: got pc=%b stall=%b expected 1/0", PC_Write, Pipe_Stall);
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({stall_cycles_o, Pipe_Stall, mem_timeout_o} !== {4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL memwait_hit: got stall_cycles=%0d stall=%b to=%b expected 3/0/0", stall_cycles_o, Pipe_Stall, mem_timeout_o);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({IF_ID_Flush, PC_Write, IF_ID_Write} !== 3'b111) begin
      errors++;
      $display("FAIL branch_flush: got %b expected 111", {IF_ID_Flush, PC_Write, IF_ID_Write});
    end
    drive(1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({IF_ID_Flush, ID_EX_Bubble, flush_count_o} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL branch_loaduse: got flush=%b bubble=%b cnt=%0d expected 0/1/1", IF_ID_Flush, ID_EX_Bubble, flush_count_o);
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({IF_ID_Flush, Pipe_Stall} !== 2'b01) begin
      errors++;
      $display("FAIL branch_memwait: got flush=%b stall=%b expected 0/1", IF_ID_Flush, Pipe_Stall);
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({IF_ID_Flush, Pipe_Stall} !== 2'b10) begin
      errors++;
      $display("FAIL branch_after_ack: got flush=%b stall=%b expected 1/0", IF_ID_Flush, Pipe_Stall);
    end
    idle();
    checks++;
    if ({flush_count_o, stall_cycles_o} !== {4'd2, 4'd2}) begin
      errors++;
      $display("FAIL branch_counts: got flush=%0d stall=%0d expected 2/2", flush_count_o, stall_cycles_o);
    end
    $display("test_branch done");
  endtask

  task automatic test_timeout();
    do_reset();
    // One RUN stall cycle followed by MW waiting cycles leads to the error state.
    for (int i = 0; i <= MW; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({mem_timeout_o, Pipe_Stall} !== 2'b01) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got to=%b stall=%b expected 0/1", i, mem_timeout_o, Pipe_Stall);
      end
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({mem_timeout_o, Pipe_Stall, PC_Write} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_ack_ignored: got to=%b stall=%b pc=%b expected 1/1/0", mem_timeout_o, Pipe_Stall, PC_Write);
    end
    idle();
    checks++;
    if ({mem_timeout_o, Pipe_Stall} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_held: got to=%b stall=%b expected 1/1", mem_timeout_o, Pipe_Stall);
    end
    do_reset();
    idle();
    checks++;
    if ({mem_timeout_o, Pipe_Stall, PC_Write, stall_cycles_o} !== {3'b001, 4'd0}) begin
      errors++;
      $display("FAIL timeout_reset: got to=%b stall=%b pc=%b cnt=%0d expected 0/0/1/0", mem_timeout_o, Pipe_Stall, PC_Write, stall_cycles_o);
    end
    $display("test_timeout done");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (stall_cycles_o !== CW'((i > SAT) ? SAT : i)) begin
        errors++;
        $display("FAIL sat_count[%0d]: got %0d expected %0d", i, stall_cycles_o, (i > SAT) ? SAT : i);
      end
    end
    do_reset();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({PC_Write, Pipe_Stall} !== 2'b10) begin
      errors++;
      $display("FAIL midwait_rst_ctrl: got pc=%b stall=%b expected 1/0", PC_Write, Pipe_Stall);
    end
    idle();
    checks++;
    if ({Pipe_Stall, PC_Write, stall_cycles_o, flush_count_o} !== {2'b01, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL midwait_rst_run: got stall=%b pc=%b cnt=%0d/%0d expected 0/1/0/0", Pipe_Stall, PC_Write, stall_cycles_o, flush_count_o);
    end
    $display("test_saturation done");
  endtask

  // Reference model: tracks whether an access is outstanding, how long it has waited,
  // whether it has timed out, and the two saturating event totals.
  task automatic test_random();
    bit mPending = 0, mDead = 0;
    int mWaited = 0, mStall = 0, mFlush = 0;
    bit r, mr, br, acc, ack, frozen, lu;
    logic [4:0] exRt, rs, rt;
    logic [4:0] expCtrl;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 49) == 0);
      mr   = $urandom_range(0, 1);
      exRt = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      br   = ($urandom_range(0, 2) == 0);
      acc  = ($urandom_range(0, 2) == 0);
      ack  = ($urandom_range(0, 3) == 0);
      drive(r, mr, exRt, rs, rt, br, acc, ack);
      lu = mr && (exRt != 0) && (exRt == rs || exRt == rt);
      frozen = mDead || (mPending && !ack) || (!mPending && acc && !ack);
      if (r)           expCtrl = 5'b11000;
      else if (frozen) expCtrl = 5'b00001;
      else if (lu)     expCtrl = 5'b00010;
      else if (br)     expCtrl = 5'b11100;
      else             expCtrl = 5'b11000;
      checks++;
      if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Stall} !== expCtrl) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Stall}, expCtrl);
      end
      checks++;
      if (mem_timeout_o !== mDead) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: got %b expected %b", n, mem_timeout_o, mDead);
      end
      checks++;
      if ({stall_cycles_o, flush_count_o} !== {CW'(mStall), CW'(mFlush)}) begin
        errors++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", n, stall_cycles_o, flush_count_o, mStall, mFlush);
      end
      if (r) begin
        mPending = 0; mDead = 0; mWaited = 0; mStall = 0; mFlush = 0;
      end else begin
        if (expCtrl[4] == 1'b0 && mStall < SAT) mStall++;
        if (expCtrl[2] == 1'b1 && mFlush < SAT) mFlush++;
        if (!mDead) begin
          if (mPending) begin
            if (ack) mPending = 0;
            else begin
              mWaited++;
              if (mWaited == MW) begin mDead = 1; mPending = 0; end
            end
          end else if (acc && !ack) begin
            mPending = 1; mWaited = 0;
          end
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst_i = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0;
    Branch_Taken = 1'b0; EX_MEM_MemAccess = 1'b0; mem_ack_i = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
